// File: rtl/dht_reader_if.sv
// rtl/dht_reader_if.sv - DHT single-wire line and measurement result bundle
//
// Groups the sensor pad signals and the result outputs of dht_reader.
//   dht_in     sensor line as seen at the pad (asynchronous to clk)
//   dht_oe     1 = pad pulls the line low, 0 = released to the pull-up
//   tem_hum_o  {humidity x10 [31:16], temperature x10 [15:0]}
//   valid_o    one-cycle pulse when tem_hum_o is updated
//   err_o      sticky flag for the last failed read
//   busy_o     reader is not idle
// master: the reader. slave: the pad/consumer side.
interface dht_reader_if;
    logic        dht_in;
    logic        dht_oe;
    logic [31:0] tem_hum_o;
    logic        valid_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        input  dht_in,
        output dht_oe,
        output tem_hum_o,
        output valid_o,
        output err_o,
        output busy_o
    );

    modport slave (
        output dht_in,
        input  dht_oe,
        input  tem_hum_o,
        input  valid_o,
        input  err_o,
        input  busy_o
    );
endinterface

// File: rtl/dht_reader.sv
// rtl/dht_reader.sv - periodic DHT11/DHT22 single-wire temperature/humidity reader
//
// Every PERIOD_MS milliseconds the reader pulls the line low for START_US,
// releases it, follows the sensor acknowledge, and decodes 40 data bits by
// the length of each high phase (more than 50 us = 1). Any sensor phase that
// lasts TIMEOUT_US aborts the read and raises err_o.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  dht_reader_if.master (dht_in, dht_oe, tem_hum_o, valid_o, err_o, busy_o)
//
// Build option: define DHT_CHECKSUM_EN to reject frames whose checksum byte
// does not match the sum of the four data bytes.
module dht_reader #(
    parameter logic [5:0]  CNT_1US_MAX = 6'd49,
    parameter logic [15:0] START_US    = 16'd2000,
    parameter logic [11:0] PERIOD_MS   = 12'd2000,
    parameter logic [15:0] TIMEOUT_US  = 16'd200
) (
    input  logic         clk,
    input  logic         rst,
    dht_reader_if.master bus
);

    typedef enum logic [2:0] {
        IDLE, START, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, DONE
    } state_t;

    state_t      state, next_state;
    logic [2:0]  sync_q;       // [1:0] synchronizer, [2] registered copy
    logic [5:0]  pre_cnt;
    logic        tick;
    logic [15:0] cnt_us;
    logic [15:0] cnt_inc;
    logic [11:0] ms_cnt;
    logic [5:0]  bit_idx;
    logic [39:0] shift;
    logic        line, rise, fall;
    logic        timed_out;
    logic        frame_ok;
    logic        bit_val;
    logic        oe_q, valid_q, err_q, busy_q;
    logic [31:0] tem_hum_q;

    assign line = sync_q[1];
    assign rise = line & ~sync_q[2];
    assign fall = ~line & sync_q[2];
    assign tick = (pre_cnt == CNT_1US_MAX);

    // Phase count including the tick of the current cycle: a high phase of
    // N us then always measures exactly N, independent of prescaler phase.
    assign cnt_inc = (tick && cnt_us != 16'hFFFF) ? cnt_us + 16'd1 : cnt_us;
    assign bit_val = (cnt_inc > 16'd50);

`ifdef DHT_CHECKSUM_EN
    logic [7:0] csum_calc;
    assign csum_calc = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];
    assign frame_ok  = (csum_calc == shift[7:0]);
`else
    // Checksum byte is shifted in but ignored in this build.
    logic unused_csum;
    assign unused_csum = ^shift[7:0];
    assign frame_ok    = 1'b1;
`endif

    always_comb begin
        next_state = state;
        timed_out  = 1'b0;
        unique case (state)
            IDLE:     if (ms_cnt == PERIOD_MS) next_state = START;
            START:    if (cnt_us == START_US)  next_state = WAIT_ACK;
            WAIT_ACK: if (fall) next_state = ACK_LOW;
            ACK_LOW:  if (rise) next_state = ACK_HIGH;
            ACK_HIGH: if (fall) next_state = BIT_LOW;
            BIT_LOW:  if (rise) next_state = BIT_HIGH;
            BIT_HIGH: if (fall) next_state = (bit_idx == 6'd39) ? DONE : BIT_LOW;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
        // A stuck sensor phase overrides any edge seen in the same cycle.
        if ((state inside {WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH}) &&
            cnt_us == TIMEOUT_US) begin
            timed_out  = 1'b1;
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sync_q    <= 3'b111;   // released line idles high: no false edge
            pre_cnt   <= '0;
            cnt_us    <= '0;
            ms_cnt    <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            oe_q      <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            tem_hum_q <= '0;
        end else begin
            state   <= next_state;
            sync_q  <= {sync_q[1:0], bus.dht_in};
            pre_cnt <= tick ? 6'd0 : pre_cnt + 6'd1;

            if (next_state != state)
                cnt_us <= '0;
            else if (state == IDLE && tick && cnt_us == 16'd999)
                cnt_us <= '0;      // in IDLE cnt_us is the microsecond-in-ms count
            else
                cnt_us <= cnt_inc;

            if (state != IDLE || next_state != IDLE)
                ms_cnt <= '0;
            else if (tick && cnt_us == 16'd999 && ms_cnt != 12'hFFF)
                ms_cnt <= ms_cnt + 12'd1;

            if (state == ACK_HIGH && next_state == BIT_LOW) begin
                bit_idx <= '0;
                shift   <= '0;
            end else if (state == BIT_HIGH && fall && !timed_out) begin
                bit_idx <= bit_idx + 6'd1;
                shift   <= {shift[38:0], bit_val};
            end

            oe_q    <= (next_state == START);
            busy_q  <= (next_state != IDLE);
            valid_q <= (state == DONE) && frame_ok;

            if (state == DONE && frame_ok)
                tem_hum_q <= shift[39:8];

            if (timed_out)
                err_q <= 1'b1;
            else if (state == DONE)
                err_q <= !frame_ok;
        end
    end

    assign bus.dht_oe    = oe_q;
    assign bus.tem_hum_o = tem_hum_q;
    assign bus.valid_o   = valid_q;
    assign bus.err_o     = err_q;
    assign bus.busy_o    = busy_q;

endmodule

// File: tb/tb_dht_reader.sv
// tb/tb_dht_reader.sv - self-checking bench for dht_reader with a behavioural sensor
`timescale 1ns/1ps
module tb_dht_reader;

    localparam int CPU    = 2;        // clocks per microsecond (CNT_1US_MAX = 1)
    localparam int US     = 20;       // ns per microsecond at a 10 ns clock
    localparam int START  = 20;
    localparam int PERIOD = 1;
    localparam int TMO    = 200;
`ifdef DHT_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sensor_low = 1'b0;
    always #5 clk = ~clk;

    dht_reader_if bus();
    assign bus.dht_in = (bus.dht_oe || sensor_low) ? 1'b0 : 1'b1;

    dht_reader #(
        .CNT_1US_MAX(6'd1),
        .START_US   (16'd20),
        .PERIOD_MS  (12'd1),
        .TIMEOUT_US (16'd200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitors: valid pulses (cycles high) and dht_oe rising edges.
    int          valid_cnt = 0;
    logic [31:0] valid_data = '0;
    int          oe_rises = 0;
    logic        oe_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            valid_cnt++;
            valid_data = bus.tem_hum_o;
        end
        if (bus.dht_oe === 1'b1 && oe_prev !== 1'b1) oe_rises++;
        oe_prev = bus.dht_oe;
    end

    // Reference model state.
    logic [31:0] exp_th  = '0;
    logic        exp_err = 1'b0;
    int          hl [40];           // high-phase length in us per frame bit

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_checks++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_oe(input logic level, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.dht_oe === level) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Sensor: ack low/high 40 us each, each bit 20 us low then hl[i] us high.
    task automatic send_frame(input int abort_bit, output bit aborted);
        aborted = 1'b0;
        #(20*US); sensor_low = 1'b1;
        #(40*US); sensor_low = 1'b0;
        #(40*US);
        for (int i = 39; i >= 0; i--) begin
            sensor_low = 1'b1;
            #(20*US);
            sensor_low = 1'b0;
            if (i == abort_bit) begin
                #(10*US);
                rst = 1'b1;
                #1;
                aborted = 1'b1;
                return;
            end
            #(hl[i]*US);
        end
        sensor_low = 1'b1;
        #(20*US);
        sensor_low = 1'b0;
    endtask

    // One complete read. mode 0: random bit lengths, mode 1: 50/51 us boundary.
    task automatic do_read(input logic [15:0] hum, input logic [15:0] tem, input logic [7:0] cs,
                           input bit boundary, input int abort_bit, input int t_ref,
                           output bit aborted);
        bit ok;
        int t_rise, vc0, r0;
        logic [39:0] fr, dec;
        logic [7:0]  s;
        bit good;
        aborted = 1'b0;
        fr = {hum, tem, cs};
        for (int i = 0; i < 40; i++)
            hl[i] = boundary ? (fr[i] ? 51 : 50)
                             : (fr[i] ? int'($urandom_range(55, 75)) : int'($urandom_range(20, 40)));
        r0 = oe_rises;
        wait_oe(1'b1, 5000, ok);
        check("start_seen", 32'(ok), 32'd1);
        if (!ok) return;
        t_rise = cyc;
        if (t_ref >= 0)
            check_range("start_delay_cycles", t_rise - t_ref, PERIOD*1000*CPU - 10, PERIOD*1000*CPU + 12);
        check("busy_in_start", 32'(bus.busy_o), 32'd1);
        wait_oe(1'b0, 200, ok);
        check("start_release", 32'(ok), 32'd1);
        if (!ok) return;
        check_range("start_width_cycles", cyc - t_rise, START*CPU - 2, START*CPU + 4);
        vc0 = valid_cnt;
        send_frame(abort_bit, aborted);
        if (aborted) return;
        repeat (10) @(negedge clk);
        // Model: bit = high phase longer than 50 us, checksum = 8-bit byte sum.
        for (int i = 0; i < 40; i++) dec[i] = (hl[i] > 50);
        s = dec[39:32] + dec[31:24] + dec[23:16] + dec[15:8];
        good = !CSUM_EN || (s == dec[7:0]);
        if (good) begin
            exp_th  = dec[39:8];
            exp_err = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        check("valid_pulses", 32'(valid_cnt - vc0), 32'(good));
        if (good) check("valid_data", valid_data, exp_th);
        check("tem_hum", bus.tem_hum_o, exp_th);
        check("err", 32'(bus.err_o), 32'(exp_err));
        check("busy_after", 32'(bus.busy_o), 32'd0);
        check("oe_rises_once", 32'(oe_rises - r0), 32'd1);
    endtask

    function automatic logic [7:0] csum(input logic [15:0] h, input logic [15:0] t);
        return h[15:8] + h[7:0] + t[15:8] + t[7:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ab, ok;
        int t_ref, t_fall, t_err;
        logic [15:0] h, t;

        repeat (3) @(negedge clk);
        check("rst_oe", 32'(bus.dht_oe), 32'd0);
        check("rst_tem_hum", bus.tem_hum_o, 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_err", 32'(bus.err_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        rst = 1'b0;
        t_ref = cyc;

        // Reference frame 69.4 % / 25.0 C, correct checksum.
        do_read(16'h02B6, 16'h00FA, 8'hB2, 1'b0, -1, t_ref, ab);
        check("ref_frame_value", bus.tem_hum_o, 32'h02B6_00FA);
        // Same frame, wrong checksum.
        do_read(16'h02B6, 16'h00FA, 8'h00, 1'b0, -1, -1, ab);
        // Random good frame.
        h = 16'($urandom_range(0, 1000)); t = 16'($urandom_range(0, 800));
        do_read(h, t, csum(h, t), 1'b0, -1, -1, ab);

        // Sensor never acknowledges.
        wait_oe(1'b1, 5000, ok);
        check("tmo_start_seen", 32'(ok), 32'd1);
        wait_oe(1'b0, 200, ok);
        t_fall = cyc;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus.err_o === 1'b1) begin ok = 1'b1; break; end
        end
        check("tmo_err_seen", 32'(ok), 32'd1);
        check_range("tmo_delay_cycles", cyc - t_fall, TMO*CPU - 4, TMO*CPU + 5);
        t_err = cyc;
        exp_err = 1'b1;
        repeat (2) @(negedge clk);
        check("tmo_busy", 32'(bus.busy_o), 32'd0);
        check("tmo_tem_hum_held", bus.tem_hum_o, exp_th);
        check("tmo_err_sticky", 32'(bus.err_o), 32'd1);

        // 50/51 us boundary frame, next read a period after the timeout.
        h = 16'($urandom); t = 16'($urandom);
        do_read(h, t, csum(h, t), 1'b1, -1, t_err, ab);
        check("boundary_value", bus.tem_hum_o, {h, t});
        // Random frame with wrong checksum.
        h = 16'($urandom_range(0, 1000)); t = 16'($urandom_range(0, 800));
        do_read(h, t, csum(h, t) + 8'd1, 1'b0, -1, -1, ab);

        // Reset during bit 20 (bits sent MSB first: frame index 19).
        h = 16'($urandom); t = 16'($urandom);
        do_read(h, t, csum(h, t), 1'b0, 19, -1, ab);
        check("abort_happened", 32'(ab), 32'd1);
        check("abort_oe", 32'(bus.dht_oe), 32'd0);
        check("abort_tem_hum", bus.tem_hum_o, 32'd0);
        check("abort_valid", 32'(bus.valid_o), 32'd0);
        check("abort_err", 32'(bus.err_o), 32'd0);
        check("abort_busy", 32'(bus.busy_o), 32'd0);
        sensor_low = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        t_ref = cyc;
        exp_th = '0;
        exp_err = 1'b0;
        h = 16'($urandom_range(0, 1000)); t = 16'($urandom_range(0, 800));
        do_read(h, t, csum(h, t), 1'b0, -1, t_ref, ab);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dht_reader.md
DHT_READER -- requirements
Module: dht_reader

Interface
REQ-001 Parameter CNT_1US_MAX, default 6'd49: clk cycles per microsecond minus one (50 MHz clock).
REQ-002 Parameter START_US, default 16'd2000: host start-pulse length in microseconds.
REQ-003 Parameter PERIOD_MS, default 12'd2000: interval between read attempts, in milliseconds.
REQ-004 Parameter TIMEOUT_US, default 16'd200: maximum length of any sensor phase.
REQ-005 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 dht_in  input  1  sensor single-wire line, sampled; asynchronous to clk.
REQ-008 dht_oe  output  1  1 = pad drives the line low; 0 = released (pull-up).
REQ-009 tem_hum_o  output  32  {humidity x10 [31:16], temperature x10 [15:0]}; feeds the PWM block's humidity-flag input.
REQ-010 valid_o  output  1  one-cycle pulse when tem_hum_o is updated.
REQ-011 err_o  output  1  sticky flag for the last failed read; cleared by the next good read.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 dht_in SHALL pass through a 2-flop synchronizer; all edge decisions use the synchronized value and its registered copy.
REQ-014 A microsecond tick SHALL be generated from a free-running counter wrapping at CNT_1US_MAX; the phase counter cnt_us[15:0] advances on the tick and clears on every state change.
REQ-015 States: IDLE, START, WAIT_ACK, ACK_LOW, ACK_HIGH, BIT_LOW, BIT_HIGH, DONE.
REQ-016 IDLE: count milliseconds (1000 ticks each); at PERIOD_MS go to START; the first read SHALL occur PERIOD_MS after reset release.
REQ-017 START: dht_oe=1 for START_US, then dht_oe=0 and go to WAIT_ACK.
REQ-018 WAIT_ACK: a falling edge goes to ACK_LOW; ACK_LOW: a rising edge goes to ACK_HIGH; ACK_HIGH: a falling edge goes to BIT_LOW with bit index 0.
REQ-019 BIT_LOW: a rising edge goes to BIT_HIGH; BIT_HIGH: on the falling edge, shift in bit = (cnt_us > 50) ? 1 : 0, MSB first, into a 40-bit shift register.
REQ-020 After the 40th bit go to DONE; otherwise return to BIT_LOW.
REQ-021 Any state other than IDLE, START and DONE reaching cnt_us == TIMEOUT_US SHALL set err_o, leave tem_hum_o unchanged, release the line and return to IDLE.
REQ-022 DONE (one cycle): load tem_hum_o = shift[39:8], pulse valid_o, clear err_o, return to IDLE; checksum handling per REQ-026.
REQ-023 dht_oe SHALL be 1 only in START; all line-driving decisions are registered.
REQ-024 Counters SHALL saturate rather than wrap; the IDLE millisecond count resets on leaving IDLE.

Reset
REQ-025 On rst: state=IDLE, all counters and the shift register = 0, tem_hum_o=0, valid_o=0, err_o=0, dht_oe=0, busy_o=0; a reset mid-read SHALL release the line immediately and discard partial data.

Configuration
REQ-026 Macro DHT_CHECKSUM_EN:
- Defined: in DONE, compare shift[7:0] with the 8-bit sum of bytes [39:32]+[31:24]+[23:16]+[15:8].
  - Mismatch: set err_o, no valid_o pulse, tem_hum_o held.
  - Match: behave per REQ-022.
- Undefined: no checksum comparison; DONE always updates tem_hum_o, and err_o reflects timeouts only.

Verification
REQ-027 Reset, then wait PERIOD_MS -> dht_oe rises exactly once, stays high 2000 us, then drops; busy_o=1.
REQ-028 Sensor model returns humidity 0x02B6 (69.4%), temperature 0x00FA (25.0 C), checksum 0xB2 -> tem_hum_o=32'h02B6_00FA, valid_o one pulse, err_o=0.
REQ-029 Same frame with checksum 0x00 and DHT_CHECKSUM_EN defined -> err_o=1, no valid_o, tem_hum_o holds its previous value; macro undefined -> tem_hum_o updates.
REQ-030 Sensor never acknowledges -> err_o=1 after 200 us in WAIT_ACK, state returns to IDLE, next START occurs PERIOD_MS later.
REQ-031 Bit-high lengths of 50 us and 51 us -> decoded as 0 and 1 respectively.
REQ-032 Assert rst during bit 20 -> dht_oe=0, all outputs zero immediately; a clean read follows PERIOD_MS after release.
